// File: rtl/poly_operand_sequencer.sv
// Feeds one {A,B,C,x} operand set into the quadratic evaluator's Go/DataIn load
// protocol, then returns its result (or a timeout error) over a valid/ready handshake.
module poly_operand_sequencer #(
  parameter int GO_LOW_CYCLES  = 2,
  parameter int GO_HIGH_CYCLES = 2,
  parameter int TIMEOUT        = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [7:0] in_c,
  input  logic [7:0] in_x,
  output logic       go,
  output logic [7:0] data_out,
  input  logic [7:0] result_in,
  input  logic       result_valid_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic       out_err,
  output logic       busy
);

  localparam int CNT_MAX0 = (GO_LOW_CYCLES > GO_HIGH_CYCLES) ? GO_LOW_CYCLES : GO_HIGH_CYCLES;
  localparam int CNT_MAX  = (TIMEOUT > CNT_MAX0) ? TIMEOUT : CNT_MAX0;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRV_LOW,
    S_DRV_HIGH,
    S_WAIT_RES,
    S_HOLD
  } state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [1:0]       r_idx, w_idx_next;
  logic [3:0][7:0]  r_ops;
  logic [3:0][7:0]  w_ops_in;
  logic [3:0][7:0]  w_ops_sel;
  logic             w_accept;
  logic             w_drive;
  logic [7:0]       w_result_next;
  logic             w_err_next;

  logic             r_in_ready;
  logic             r_go;
  logic [7:0]       r_data_out;
  logic             r_out_valid;
  logic [7:0]       r_out_result;
  logic             r_out_err;
  logic             r_busy;

  assign w_ops_in  = {in_x, in_c, in_b, in_a};
  // On the accepting edge the operand latch is not yet loaded, so drive from the inputs.
  assign w_ops_sel = w_accept ? w_ops_in : r_ops;
  assign w_drive   = (w_state_next == S_DRV_LOW) || (w_state_next == S_DRV_HIGH);

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_idx_next    = r_idx;
    w_accept      = 1'b0;
    w_result_next = r_out_result;
    w_err_next    = r_out_err;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_idx_next   = 2'd0;
          w_cnt_next   = '0;
          w_state_next = S_DRV_LOW;
        end
      end
      S_DRV_LOW: begin
        if (r_cnt == CNT_W'(GO_LOW_CYCLES - 1)) begin
          w_cnt_next   = '0;
          w_state_next = S_DRV_HIGH;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DRV_HIGH: begin
        if (r_cnt == CNT_W'(GO_HIGH_CYCLES - 1)) begin
          w_cnt_next = '0;
          if (r_idx == 2'd3) begin
            w_state_next = S_WAIT_RES;
          end else begin
            w_idx_next   = r_idx + 2'd1;
            w_state_next = S_DRV_LOW;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_RES: begin
        if (result_valid_in) begin
          w_result_next = result_in;
          w_err_next    = 1'b0;
          w_cnt_next    = '0;
          w_state_next  = S_HOLD;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_result_next = 8'd0;
          w_err_next    = 1'b1;
          w_cnt_next    = '0;
          w_state_next  = S_HOLD;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_idx_next   = 2'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_ops        <= '0;
      r_in_ready   <= 1'b1;
      r_go         <= 1'b0;
      r_data_out   <= 8'd0;
      r_out_valid  <= 1'b0;
      r_out_result <= 8'd0;
      r_out_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_idx        <= w_idx_next;
      if (w_accept) begin
        r_ops <= w_ops_in;
      end
      r_in_ready   <= (w_state_next == S_IDLE);
      r_go         <= (w_state_next == S_DRV_HIGH);
      r_data_out   <= w_drive ? w_ops_sel[w_idx_next] : 8'd0;
      r_out_valid  <= (w_state_next == S_HOLD);
      r_out_result <= w_result_next;
      r_out_err    <= w_err_next;
      r_busy       <= (w_state_next != S_IDLE);
    end
  end

  assign in_ready   = r_in_ready;
  assign go         = r_go;
  assign data_out   = r_data_out;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_err    = r_out_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_poly_operand_sequencer.sv
// Directed bench for poly_operand_sequencer with a behavioural quadratic evaluator
// and a go/data_out protocol monitor attached.
module tb_poly_operand_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b, in_c, in_x;
  logic       go;
  logic [7:0] data_out;
  logic [7:0] result_in;
  logic       result_valid_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  poly_operand_sequencer #(
    .GO_LOW_CYCLES(2),
    .GO_HIGH_CYCLES(2),
    .TIMEOUT(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_c(in_c),
    .in_x(in_x),
    .go(go),
    .data_out(data_out),
    .result_in(result_in),
    .result_valid_in(result_valid_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_err(out_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Evaluator model: loads on each go rise, result valid 6 cycles after go's 4th fall.
  logic       ev_en;
  logic       ev_pg;
  logic       ev_rv;
  logic [7:0] ev_res;
  logic [7:0] ev_ops [4];
  int         ev_n;
  int         ev_dly;

  assign result_valid_in = ev_rv & ev_en;
  assign result_in       = ev_res;

  always @(posedge clk) begin
    if (reset) begin
      ev_pg  <= 1'b0;
      ev_rv  <= 1'b0;
      ev_res <= 8'd0;
      ev_n   <= 0;
      ev_dly <= 0;
    end else begin
      ev_pg <= go;
      if (go && !ev_pg) begin
        if (ev_n < 4) ev_ops[ev_n[1:0]] <= data_out;
        ev_n <= ev_n + 1;
        if (ev_n == 0) ev_rv <= 1'b0;
      end
      if (!go && ev_pg && ev_n == 4) begin
        ev_dly <= 5;
        ev_n   <= 0;
      end
      if (ev_dly != 0) begin
        ev_dly <= ev_dly - 1;
        if (ev_dly == 1) begin
          ev_rv  <= 1'b1;
          ev_res <= ev_ops[0] * ev_ops[3] * ev_ops[3] + ev_ops[1] * ev_ops[3] + ev_ops[2];
        end
      end
    end
  end

  // Protocol monitor on go/data_out.
  logic       mon_clr;
  logic       mon_pg;
  logic [7:0] mon_pd;
  logic       mon_bad;
  int         mon_pulses;
  int         mon_low_run;
  int         mon_high_run;
  int         mon_low [4];
  int         mon_high [4];
  logic [7:0] mon_data [4];

  always @(posedge clk) begin
    if (mon_clr) begin
      mon_pg       <= go;
      mon_pd       <= data_out;
      mon_bad      <= 1'b0;
      mon_pulses   <= 0;
      mon_low_run  <= 0;
      mon_high_run <= 0;
    end else begin
      mon_pg <= go;
      mon_pd <= data_out;
      if (go) begin
        if (data_out != mon_pd) mon_bad <= 1'b1;
        if (!mon_pg) begin
          if (mon_pulses < 4) begin
            mon_low[mon_pulses[1:0]]  <= mon_low_run;
            mon_data[mon_pulses[1:0]] <= data_out;
          end
          mon_pulses   <= mon_pulses + 1;
          mon_high_run <= 1;
        end else begin
          mon_high_run <= mon_high_run + 1;
        end
      end else begin
        if (mon_pg && mon_pulses >= 1 && mon_pulses <= 4)
          mon_high[mon_pulses[1:0] - 2'd1] <= mon_high_run;
        if (mon_pg || data_out != mon_pd) mon_low_run <= 1;
        else mon_low_run <= mon_low_run + 1;
      end
    end
  end

  // Offer one set while idle and wait for out_valid; lat = -1 if it never comes.
  task automatic run_set(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] x, output int lat, output int fall_n);
    logic pg;
    in_a = a; in_b = b; in_c = c; in_x = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    fall_n = -1;
    pg = go;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (pg && !go) fall_n = n;
      pg = go;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    $display("txn A=%0d B=%0d C=%0d x=%0d -> result=0x%02h err=%0b lat=%0d gap=%0d",
             a, b, c, x, out_result, out_err, lat, lat - fall_n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks += 7;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (go !== 1'b0) begin errors++; $display("FAIL reset_go got %b want 0", go); end
    if (data_out !== 8'd0) begin errors++; $display("FAIL reset_data_out got %h want 00", data_out); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_result !== 8'd0) begin errors++; $display("FAIL reset_out_result got %h want 00", out_result); end
    if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int lat, fall_n;
    out_ready = 1'b1;
    run_set(8'd2, 8'd3, 8'd4, 8'd5, lat, fall_n);
    checks += 4;
    if (lat !== 23) begin errors++; $display("FAIL basic_latency got %0d want 23", lat); end
    if (lat - fall_n !== 7) begin errors++; $display("FAIL basic_fall_gap got %0d want 7", lat - fall_n); end
    if (out_result !== 8'h45) begin errors++; $display("FAIL basic_result got %h want 45", out_result); end
    if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", out_err); end
    @(posedge clk); #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_release_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat, fall_n;
    out_ready = 1'b1;
    run_set(8'd10, 8'd0, 8'd0, 8'd10, lat, fall_n);
    checks += 2;
    if (lat !== 23) begin errors++; $display("FAIL ovf_latency got %0d want 23", lat); end
    if (out_result !== 8'hE8) begin errors++; $display("FAIL ovf_result got %h want e8", out_result); end
    @(posedge clk); #1;
    checks += 1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    run_set(8'd0, 8'd0, 8'd7, 8'd9, lat, fall_n);
    checks += 3;
    if (lat !== 23) begin errors++; $display("FAIL b2b_latency got %0d want 23", lat); end
    if (out_result !== 8'h07) begin errors++; $display("FAIL b2b_result got %h want 07", out_result); end
    if (out_err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b want 0", out_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_protocol();
    int lat, fall_n;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    out_ready = 1'b1;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    run_set(8'h11, 8'h22, 8'h33, 8'h44, lat, fall_n);
    checks += 3;
    if (mon_pulses !== 4) begin errors++; $display("FAIL proto_pulses got %0d want 4", mon_pulses); end
    if (mon_bad !== 1'b0) begin errors++; $display("FAIL proto_stable got %b want 0", mon_bad); end
    if (out_result !== 8'h4B) begin errors++; $display("FAIL proto_result got %h want 4b", out_result); end
    for (int i = 0; i < 4; i++) begin
      checks += 3;
      if (mon_high[i] !== 2) begin errors++; $display("FAIL proto_high[%0d] got %0d want 2", i, mon_high[i]); end
      if (mon_low[i] < 2) begin errors++; $display("FAIL proto_low[%0d] got %0d want >=2", i, mon_low[i]); end
      if (mon_data[i] !== exp_d[i]) begin errors++; $display("FAIL proto_data[%0d] got %h want %h", i, mon_data[i], exp_d[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat, fall_n;
    out_ready = 1'b0;
    run_set(8'd1, 8'd2, 8'd3, 8'd4, lat, fall_n);
    checks += 2;
    if (lat !== 23) begin errors++; $display("FAIL bp_latency got %0d want 23", lat); end
    if (out_result !== 8'h1B) begin errors++; $display("FAIL bp_result got %h want 1b", out_result); end
    in_a = 8'd9; in_b = 8'd9; in_c = 8'd9; in_x = 8'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, out_valid); end
      if (out_result !== 8'h1B) begin errors++; $display("FAIL bp_hold_result[%0d] got %h want 1b", i, out_result); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d] got %b want 0", i, in_ready); end
      if (go !== 1'b0) begin errors++; $display("FAIL bp_hold_go[%0d] got %b want 0", i, go); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %b want 0", busy); end
    repeat (2) @(posedge clk);
    #1;
    checks += 1;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_accept got busy=%b want 0", busy); end
    $display("txn backpressure released, in_ready=%b busy=%b", in_ready, busy);
  endtask

  task automatic test_timeout();
    int lat, fall_n;
    out_ready = 1'b1;
    ev_en = 1'b0;
    run_set(8'd2, 8'd3, 8'd4, 8'd5, lat, fall_n);
    ev_en = 1'b1;
    checks += 4;
    if (lat - fall_n !== 32) begin errors++; $display("FAIL to_wait_cycles got %0d want 32", lat - fall_n); end
    if (lat !== 48) begin errors++; $display("FAIL to_latency got %0d want 48", lat); end
    if (out_err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", out_err); end
    if (out_result !== 8'd0) begin errors++; $display("FAIL to_result got %h want 00", out_result); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, fall_n;
    out_ready = 1'b1;
    in_a = 8'd2; in_b = 8'd3; in_c = 8'd4; in_x = 8'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checks += 2;
    if (go !== 1'b1) begin errors++; $display("FAIL rmid_x_high got %b want 1", go); end
    if (data_out !== 8'd5) begin errors++; $display("FAIL rmid_x_data got %h want 05", data_out); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks += 3;
    if (go !== 1'b0) begin errors++; $display("FAIL rmid_go got %b want 0", go); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    run_set(8'd1, 8'd1, 8'd1, 8'd1, lat, fall_n);
    checks += 3;
    if (lat !== 23) begin errors++; $display("FAIL rmid_latency got %0d want 23", lat); end
    if (out_result !== 8'h03) begin errors++; $display("FAIL rmid_result got %h want 03", out_result); end
    if (out_err !== 1'b0) begin errors++; $display("FAIL rmid_err got %b want 0", out_err); end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = 8'd0; in_b = 8'd0; in_c = 8'd0; in_x = 8'd0;
    out_ready = 1'b0;
    ev_en = 1'b1;
    mon_clr = 1'b1;
    test_reset();
    mon_clr = 1'b0;
    test_basic();
    test_back_to_back();
    test_protocol();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
